// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/stall controller for a five-stage pipeline.
// Produces PC and pipeline-register write enables, IF/ID flush and ID/EX
// bubble, plus a RUN/IWAIT/DWAIT/HALT state machine.
// Optional stall-cycle counter is enabled by defining PIPE_CTRL_STALL_CNT_EN;
// without it stall_cnt reads as zero and cnt_clr is ignored.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hz_stall,
  input  logic        ex_redirect,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  input  logic        halt_req,
  input  logic        cnt_clr,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   squash_q, squash_d;

  assign state = state_q;

  // State and squash-flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  // Next-state and combinational pipeline controls, in priority order
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    squash_d     = squash_q;

    if (!rst_n) begin
      // Everything held inactive while reset is asserted.
      state_d  = RUN;
      squash_d = 1'b0;
    end else if (state_q == HALT) begin
      halted = 1'b1;
    end else begin
      if (dmem_busy) begin
        // Whole pipeline frozen; squash flag untouched.
        state_d = DWAIT;
      end else if (ex_redirect) begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        // Set wins over clear: an outstanding fetch means a stale
        // instruction is still in flight from the old path.
        squash_d     = imem_busy;
        state_d      = imem_busy ? IWAIT : RUN;
      end else if (squash_q && !imem_busy) begin
        // Stale fetch from before the redirect arrives now: discard it
        // and let the PC advance past the redirect target.
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_id_flush = 1'b1;
        squash_d    = 1'b0;
        state_d     = RUN;
      end else if (hz_stall) begin
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end else if (imem_busy) begin
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_id_flush = 1'b1;
        state_d     = IWAIT;
      end else begin
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        id_ex_we  = 1'b1;
        ex_mem_we = 1'b1;
        mem_wb_we = 1'b1;
        state_d   = RUN;
      end

      // HALT only commits once the instruction actually retires out of MEM.
      if (halt_req && mem_wb_we) begin
        state_d = HALT;
      end
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] cnt_q;

  // Saturating stall-cycle counter, clear has priority over increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (!pc_we && (state_q != HALT) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign stall_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl. Each vector pushes
// its hand-computed expected outputs; a negedge monitor pops and compares.
// Counter expectations follow PIPE_CTRL_STALL_CNT_EN.
`ifdef PIPE_CTRL_STALL_CNT_EN
`define TB_CNT(v) (v)
`else
`define TB_CNT(v) 16'h0000
`endif

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hz_stall = 1'b0, ex_redirect = 1'b0, imem_busy = 1'b0;
  logic        dmem_busy = 1'b0, halt_req = 1'b0, cnt_clr = 1'b0;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_bubble, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] ALL  = 7'b1111100;
  localparam logic [6:0] RDIR = 7'b1111111;
  localparam logic [6:0] HZ   = 7'b0011101;
  localparam logic [6:0] IBSY = 7'b0111110;
  localparam logic [6:0] SQ   = 7'b1111110;

  typedef struct {
    string       name;
    logic [6:0]  en;
    logic        hlt;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_stall     (hz_stall),
    .ex_redirect  (ex_redirect),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .halt_req     (halt_req),
    .cnt_clr      (cnt_clr),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .halted       (halted),
    .state        (state),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble};
      checks++;
      if (act !== e.en) begin
        errors++;
        $display("FAIL %s enables: got %b expected %b", e.name, act, e.en);
      end
      checks++;
      if (halted !== e.hlt) begin
        errors++;
        $display("FAIL %s halted: got %b expected %b", e.name, halted, e.hlt);
      end
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", e.name, state, e.st);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %h expected %h", e.name, stall_cnt, e.cnt);
      end
    end
  end

  task automatic drive(input bit rst, input bit hz, input bit rd, input bit ib,
                       input bit db, input bit hr, input bit clr);
    @(posedge clk);
    #1;
    rst_n       = rst;
    hz_stall    = hz;
    ex_redirect = rd;
    imem_busy   = ib;
    dmem_busy   = db;
    halt_req    = hr;
    cnt_clr     = clr;
  endtask

  task automatic vec(input string nm, input bit rst, input bit hz, input bit rd,
                     input bit ib, input bit db, input bit hr, input bit clr,
                     input logic [6:0] en, input logic h, input logic [1:0] st,
                     input logic [15:0] cnt);
    exp_t e;
    drive(rst, hz, rd, ib, db, hr, clr);
    e.name = nm; e.en = en; e.hlt = h; e.st = st; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    //        name            rst hz rd ib db hr clr  en    h  st  cnt
    vec("reset",             0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, `TB_CNT(0));
    vec("run",               1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(0));
    vec("hz_stall",          1, 1, 0, 0, 0, 0, 0, HZ,   0, 0, `TB_CNT(0));
    vec("after_stall",       1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(1));
    vec("dwait0",            1, 0, 1, 0, 1, 0, 0, NONE, 0, 0, `TB_CNT(1));
    vec("dwait1",            1, 0, 1, 0, 1, 0, 0, NONE, 0, 2, `TB_CNT(2));
    vec("dwait2",            1, 0, 1, 0, 1, 0, 0, NONE, 0, 2, `TB_CNT(3));
    vec("redir_after_dw",    1, 0, 1, 0, 0, 0, 0, RDIR, 0, 2, `TB_CNT(4));
    vec("idle1",             1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(4));
    vec("redir_ibusy",       1, 0, 1, 1, 0, 0, 0, RDIR, 0, 0, `TB_CNT(4));
    vec("ibusy1",            1, 0, 0, 1, 0, 0, 0, IBSY, 0, 1, `TB_CNT(4));
    vec("ibusy2",            1, 0, 0, 1, 0, 0, 0, IBSY, 0, 1, `TB_CNT(5));
    vec("squash_clr",        1, 0, 0, 0, 0, 0, 0, SQ,   0, 1, `TB_CNT(6));
    vec("idle2",             1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(6));
    vec("redir_ib_a",        1, 0, 1, 1, 0, 0, 0, RDIR, 0, 0, `TB_CNT(6));
    vec("redir_ib_b",        1, 0, 1, 1, 0, 0, 0, RDIR, 0, 1, `TB_CNT(6));
    vec("squash_clr2",       1, 0, 0, 0, 0, 0, 0, SQ,   0, 1, `TB_CNT(6));
    vec("idle3",             1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(6));
    vec("halt_frozen",       1, 0, 0, 0, 1, 1, 0, NONE, 0, 0, `TB_CNT(6));
    vec("halt_req",          1, 0, 0, 0, 0, 1, 0, ALL,  0, 2, `TB_CNT(7));
    for (int i = 0; i < 10; i++) begin
      vec("halted",          1, i[0], i[1], 0, 0, 0, 0, NONE, 1, 3, `TB_CNT(7));
    end
    vec("halt_rst",          0, 0, 0, 0, 0, 0, 0, NONE, 0, 3, `TB_CNT(7));
    vec("post_rst",          1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(0));
    vec("hz_clr",            1, 1, 0, 0, 0, 0, 1, HZ,   0, 0, `TB_CNT(0));
    vec("idle4",             1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(0));
    vec("redir_hz",          1, 1, 1, 0, 0, 0, 0, RDIR, 0, 0, `TB_CNT(0));
    vec("idle5",             1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(0));
    vec("hz_ibusy",          1, 1, 0, 1, 0, 0, 0, HZ,   0, 0, `TB_CNT(0));
    vec("idle6",             1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, `TB_CNT(1));
`ifdef PIPE_CTRL_STALL_CNT_EN
    // Bring the counter from 1 up to 16'hFFFE with unchecked stall cycles.
    for (int i = 0; i < 65533; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0);
    end
    vec("pre_fffe",          1, 1, 0, 0, 0, 0, 0, HZ,   0, 0, 16'hFFFE);
    vec("pre_ffff",          1, 1, 0, 0, 0, 0, 0, HZ,   0, 0, 16'hFFFF);
    vec("sat_ffff",          1, 1, 0, 0, 0, 0, 0, HZ,   0, 0, 16'hFFFF);
    vec("sat_clr",           1, 1, 0, 0, 0, 0, 1, HZ,   0, 0, 16'hFFFF);
    vec("after_clr",         1, 0, 0, 0, 0, 0, 0, ALL,  0, 0, 16'h0000);
`endif
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
